// File: rtl/pyramic_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pyramic_adc_pkg
// Description : Shared types and constants for the Pyramic ADC responder and
//               its SPI master counterpart.
// Revision    : 1.0 - initial release
// ============================================================================
package pyramic_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        READY   = 2'd2,
        SHIFT   = 2'd3
    } adc_state_t;

    localparam int PATTERN_CH_W        = 3;
    localparam int SAMPLE_W_DEFAULT    = 16;
    localparam int CH_PER_LINE_DEFAULT = 4;
    localparam int BITS_PER_LINE       = SAMPLE_W_DEFAULT * CH_PER_LINE_DEFAULT;

    localparam int ERR_CONVST = 0;
    localparam int ERR_CSN    = 1;

endpackage
`default_nettype wire

// File: rtl/pin_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : pin_sync_edge
// Description : Two-flop synchronizer for an asynchronous pin, followed by an
//               edge-detect register producing single-cycle rise/fall strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module pin_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Reset to the pin's idle level so releasing reset creates no false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
            prev_q  <= RST_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/pyramic_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : pyramic_adc_responder
// Description : Device-side model of an AD7606-style converter pair for the
//               Pyramic SPI acquisition path; oversamples the master's pins.
// Revision    : 1.0 - initial release
// ============================================================================
module pyramic_adc_responder
    import pyramic_adc_pkg::*;
#(
    parameter int CONV_CYCLES = 200,
    parameter int SAMPLE_W    = SAMPLE_W_DEFAULT,
    parameter int CH_PER_LINE = CH_PER_LINE_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              convst,
    input  logic                              cs_n,
    input  logic                              sclk,
    output logic                              busy,
    output logic                              miso_0,
    output logic                              miso_1,
    input  logic                              ext_sel,
    input  logic [2*SAMPLE_W*CH_PER_LINE-1:0] ext_data,
    output logic [15:0]                       frame_count,
    output logic [1:0]                        err_flags,
    input  logic                              err_clear
);

    localparam int LINE_W    = SAMPLE_W * CH_PER_LINE;
    localparam int BIT_CNT_W = $clog2(LINE_W + 1);
    localparam logic [BIT_CNT_W-1:0] LINE_BITS = BIT_CNT_W'(LINE_W);
    localparam logic [15:0]          CONV_LOAD = 16'(CONV_CYCLES - 1);

    logic convst_level, convst_rise, convst_fall;
    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic unused_pins;

    pin_sync_edge #(.RST_VAL(1'b0)) u_sync_convst (
        .clk(clk), .reset(reset), .pin(convst),
        .level(convst_level), .rise(convst_rise), .fall(convst_fall)
    );
    pin_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );
    pin_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign unused_pins = ^{convst_level, convst_fall, cs_level, sclk_level, sclk_rise};

    adc_state_t            state_q, state_d;
    logic [15:0]           conv_cnt_q, conv_cnt_d;
    logic [15:0]           frame_count_q, frame_count_d;
    logic [1:0]            err_q, err_d;
    logic [LINE_W-1:0]     sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LINE_W-1:0]     load_a, load_b;
    logic [SAMPLE_W-1:0]   word;
    logic                  start;

    // Frame image: ascending channel order, MSB first; pattern tags the channel.
    always_comb begin
        load_a = '0;
        load_b = '0;
        word   = '0;
        for (int c = 0; c < 2 * CH_PER_LINE; c++) begin
            word = '0;
            word[SAMPLE_W-1 -: PATTERN_CH_W]           = PATTERN_CH_W'(c);
            word[SAMPLE_W-PATTERN_CH_W-1:0]            = frame_count_q[SAMPLE_W-PATTERN_CH_W-1:0];
            if (ext_sel) begin
                word = ext_data[c*SAMPLE_W +: SAMPLE_W];
            end
            if (c < CH_PER_LINE) begin
                load_a[LINE_W-1-c*SAMPLE_W -: SAMPLE_W] = word;
            end else begin
                load_b[LINE_W-1-(c-CH_PER_LINE)*SAMPLE_W -: SAMPLE_W] = word;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        conv_cnt_d    = conv_cnt_q;
        frame_count_d = frame_count_q;
        err_d         = err_clear ? 2'b00 : err_q;
        sh_a_d        = sh_a_q;
        sh_b_d        = sh_b_q;
        bit_cnt_d     = bit_cnt_q;
        start         = 1'b0;

        case (state_q)
            IDLE: begin
                start = convst_rise;
                if (cs_fall) err_d[ERR_CSN] = 1'b1;
            end
            CONVERT: begin
                if (convst_rise) err_d[ERR_CONVST] = 1'b1;
                if (cs_fall)     err_d[ERR_CSN]    = 1'b1;
                if (conv_cnt_q == '0) begin
                    state_d       = READY;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    conv_cnt_d = conv_cnt_q - 16'd1;
                end
            end
            READY: begin
                if (convst_rise) begin
                    start = 1'b1;
                end else if (cs_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (convst_rise) begin
                    start = 1'b1;
                end else if (cs_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end else if (sclk_fall && (bit_cnt_q < LINE_BITS)) begin
                    sh_a_d    = {sh_a_q[LINE_W-2:0], 1'b0};
                    sh_b_d    = {sh_b_q[LINE_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d    = CONVERT;
            conv_cnt_d = CONV_LOAD;
            sh_a_d     = load_a;
            sh_b_d     = load_b;
            bit_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            conv_cnt_q    <= '0;
            frame_count_q <= '0;
            err_q         <= '0;
            sh_a_q        <= '0;
            sh_b_q        <= '0;
            bit_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            conv_cnt_q    <= conv_cnt_d;
            frame_count_q <= frame_count_d;
            err_q         <= err_d;
            sh_a_q        <= sh_a_d;
            sh_b_q        <= sh_b_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

    assign busy        = (state_q == CONVERT);
    assign miso_0      = (state_q == SHIFT) && (bit_cnt_q < LINE_BITS) && sh_a_q[LINE_W-1];
    assign miso_1      = (state_q == SHIFT) && (bit_cnt_q < LINE_BITS) && sh_b_q[LINE_W-1];
    assign frame_count = frame_count_q;
    assign err_flags   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pyramic_adc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pyramic_adc_responder
// Description : Randomized scoreboard bench for pyramic_adc_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pyramic_adc_responder;

    localparam int CONV = 200;

    logic         clk = 1'b0;
    logic         reset, convst, cs_n, sclk, ext_sel, err_clear;
    logic [127:0] ext_data;
    logic         busy, miso_0, miso_1;
    logic [15:0]  frame_count;
    logic [1:0]   err_flags;

    pyramic_adc_responder #(.CONV_CYCLES(CONV), .SAMPLE_W(16), .CH_PER_LINE(4)) dut (
        .clk(clk), .reset(reset), .convst(convst), .cs_n(cs_n), .sclk(sclk),
        .busy(busy), .miso_0(miso_0), .miso_1(miso_1),
        .ext_sel(ext_sel), .ext_data(ext_data),
        .frame_count(frame_count), .err_flags(err_flags), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];

    int           model_frame;
    bit           lat_sel;
    logic [127:0] lat_data;
    int           lat_frame;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word the master should see for channel c of the latched frame.
    function automatic logic [15:0] exp_word(input int c);
        if (lat_sel) return lat_data[16*c +: 16];
        return 16'((c * 8192) + (lat_frame % 8192));
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: compares every word the master captures.
    initial begin
        logic [15:0] o, e;
        forever begin
            @(negedge clk);
            while (obs_a.size() > 0) begin
                o = obs_a.pop_front();
                if (exp_a.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL line_a_unexpected: got 0x%0h expected none", o);
                end else begin
                    e = exp_a.pop_front();
                    check("line_a_word", o, e);
                end
            end
            while (obs_b.size() > 0) begin
                o = obs_b.pop_front();
                if (exp_b.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL line_b_unexpected: got 0x%0h expected none", o);
                end else begin
                    e = exp_b.pop_front();
                    check("line_b_word", o, e);
                end
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_convert(input int glitch_at, input int cs_fall_at, input bit scramble);
        int hi;
        bit done;
        lat_sel   = ext_sel;
        lat_data  = ext_data;
        lat_frame = model_frame;
        hi   = 0;
        done = 0;
        convst = 1'b1;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(negedge clk);
            if (k == 2) convst = 1'b0;
            if (busy) begin
                hi++;
                if (hi == glitch_at) convst = 1'b1;
                if (glitch_at > 0 && hi == glitch_at + 3) convst = 1'b0;
                if (hi == cs_fall_at) cs_n = 1'b0;
                if (scramble && hi == 5) ext_data = rand128();
            end else if (hi > 0) begin
                done = 1;
            end
        end
        model_frame = (model_frame + 1) % 65536;
        check("busy_len", hi, CONV);
        check("frame_count", frame_count, model_frame);
    endtask

    task automatic cs_fall();
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_rise();
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_read(input int nbits, input int half);
        logic [15:0] ba, bb;
        ba = '0;
        bb = '0;
        for (int w = 0; w < nbits / 16; w++) begin
            exp_a.push_back(exp_word(w));
            exp_b.push_back(exp_word(w + 4));
        end
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            ba = {ba[14:0], miso_0};
            bb = {bb[14:0], miso_1};
            if (i % 16 == 15) begin
                obs_a.push_back(ba);
                obs_b.push_back(bb);
            end
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            repeat (half - 1) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic quiet(input int ncyc, input string name);
        bit bad;
        bad = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (k % 5 == 0) sclk = ~sclk;
            if (miso_0 || miso_1) bad = 1;
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        check(name, bad, 0);
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("err_cleared", err_flags, 2'b00);
    endtask

    initial begin
        reset = 1'b1; convst = 1'b0; cs_n = 1'b1; sclk = 1'b0;
        ext_sel = 1'b0; ext_data = '0; err_clear = 1'b0;
        model_frame = 0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_miso_0", miso_0, 0);
        check("rst_miso_1", miso_1, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_err", err_flags, 0);

        // Frame 0, internal pattern.
        do_convert(0, 0, 0);
        cs_fall();
        spi_read(64, 5);
        cs_rise();
        check("err_after_read", err_flags, 2'b00);

        // External words.
        ext_sel  = 1'b1;
        ext_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        do_convert(0, 0, 0);
        cs_fall();
        spi_read(64, 5);
        cs_rise();
        ext_sel = 1'b0;

        // convst during CONVERT.
        do_convert(50, 0, 0);
        check("err_convst", err_flags, 2'b01);
        clear_err();

        // cs_n fall during CONVERT, held low into READY.
        do_convert(0, 20, 0);
        check("err_csn_convert", err_flags, 2'b10);
        quiet(30, "miso_ready_cs_low");
        clear_err();
        cs_rise();
        cs_fall();
        spi_read(20, 5);
        cs_rise();
        cs_fall();
        check("err_csn_idle", err_flags, 2'b10);
        quiet(30, "miso_idle_cs_low");
        cs_rise();
        clear_err();

        // New conversion abandons a shift in progress.
        do_convert(0, 0, 0);
        cs_fall();
        spi_read(10, 5);
        do_convert(0, 0, 0);
        quiet(30, "miso_after_abandon");
        cs_rise();
        cs_fall();
        spi_read(64, 6);
        cs_rise();

        // Reset in the middle of a shift.
        do_convert(0, 0, 0);
        cs_fall();
        spi_read(30, 5);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_miso_0", miso_0, 0);
        check("midrst_miso_1", miso_1, 0);
        check("midrst_frame_count", frame_count, 0);
        check("midrst_err", err_flags, 0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        model_frame = 0;
        do_convert(0, 0, 0);
        cs_fall();
        spi_read(64, 5);
        cs_rise();

        // Randomized frames; ext_data is disturbed mid-conversion.
        for (int r = 0; r < 8; r++) begin
            ext_sel  = 1'($urandom % 2);
            ext_data = rand128();
            do_convert(0, 0, 1);
            cs_fall();
            spi_read(64, int'($urandom_range(4, 7)));
            cs_rise();
        end

        repeat (20) @(negedge clk);
        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        check("err_final", err_flags, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
